jtdd_dwnld: RTL

Download stage sitting directly upstream of the game top level's ROM loader. It converts the byte-wide ioctl download stream into relocated SDRAM word writes. It also generates the 4-bit priority-PROM write strobe. A 2-entry write buffer decouples ioctl_wr bursts from the SDRAM acknowledge latency. A busy flag holds the game in reset until every byte has been committed.

---
 rtl/jtdd_dwnld_if.sv | 27 ++
 rtl/jtdd_dwnld.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jtdd_dwnld_if.sv
// Bundle of the download-stage signals: ioctl byte stream in, SDRAM/PROM programming out.
//   slave  : the download stage (jtdd_dwnld)
//   master : the ioctl source / SDRAM side driving it
interface jtdd_dwnld_if;
  logic        downloading;  // download in progress
  logic [21:0] ioctl_addr;   // byte offset in .rom file
  logic [7:0]  ioctl_data;   // download byte
  logic        ioctl_wr;     // one-cycle byte strobe
  logic [21:0] prog_addr;    // SDRAM word address, [7:0] doubles as PROM address
  logic [7:0]  prog_data;    // byte to write, [3:0] doubles as PROM data
  logic [1:0]  prog_mask;    // active-low byte-lane mask
  logic        prog_we;      // SDRAM request, held until sdram_ack
  logic        sdram_ack;    // SDRAM accepted current request
  logic        prom_we;      // one-cycle priority-PROM write pulse
  logic        dwnld_busy;   // download running or writes still pending
  logic        ovf;          // sticky: a byte was dropped on a full buffer

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, ovf
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we, prom_we, dwnld_busy, ovf
  );
endinterface

// File: rtl/jtdd_dwnld.sv
// Download stage: relocates the byte-wide ioctl stream into SDRAM word writes and
// priority-PROM writes, decoupled from SDRAM acknowledge latency by a 2-entry buffer.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   bus   : jtdd_dwnld_if.slave (ioctl stream in, prog_*/prom_we/busy/ovf out)
module jtdd_dwnld #(
  parameter logic [21:0] SCR_START  = 22'h06_0000,
  parameter logic [21:0] OBJ_START  = 22'h0A_0000,
  parameter logic [21:0] MCU_START  = 22'h12_0000,
  parameter logic [21:0] PROM_START = 22'h12_4000,
  parameter logic [21:0] SCR_ADDR   = 22'h06_0000,
  parameter logic [21:0] OBJ_ADDR   = 22'h08_0000,
  parameter logic [21:0] MCU_ADDR   = 22'h0C_0000
) (
  input logic         clk,
  input logic         rst_n,
  jtdd_dwnld_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  typedef struct packed {
    logic [21:0] word;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic        is_prom;
  } entry_t;

  function automatic logic [1:0] lane_mask(input logic high);
    return high ? 2'b01 : 2'b10;
  endfunction

  // Region offsets, truncated to the bits each region actually uses.
  logic [17:0] off_scr;
  logic [18:0] off_obj;
  logic [13:0] off_mcu;
  logic [7:0]  off_prom;
  entry_t      in_entry;
  logic        in_keep;

  always_comb begin
    off_scr  = 18'(bus.ioctl_addr - SCR_START);
    off_obj  = 19'(bus.ioctl_addr - OBJ_START);
    off_mcu  = 14'(bus.ioctl_addr - MCU_START);
    off_prom = 8'(bus.ioctl_addr - PROM_START);
    in_entry = '0;
    in_entry.data = bus.ioctl_data;
    in_entry.mask = 2'b11;
    in_keep  = 1'b1;
    if (bus.ioctl_addr < SCR_START) begin
      in_entry.word = {1'b0, bus.ioctl_addr[21:1]};
      in_entry.mask = lane_mask(bus.ioctl_addr[0]);
    end else if (bus.ioctl_addr < OBJ_START) begin
      in_entry.word = SCR_ADDR + {5'd0, off_scr[16:0]};
      in_entry.mask = lane_mask(off_scr[17]);
    end else if (bus.ioctl_addr < MCU_START) begin
      in_entry.word = OBJ_ADDR + {4'd0, off_obj[17:0]};
      in_entry.mask = lane_mask(off_obj[18]);
    end else if (bus.ioctl_addr < PROM_START) begin
      in_entry.word = MCU_ADDR + {8'd0, off_mcu};
      in_entry.mask = 2'b10;
    end else if (bus.ioctl_addr < PROM_START + 22'h100) begin
      in_entry.word    = {14'd0, off_prom};
      in_entry.is_prom = 1'b1;
    end else begin
      in_keep = 1'b0;
    end
  end

  logic        state_q;
  logic [21:0] prog_addr_q;
  logic [7:0]  prog_data_q;
  logic [1:0]  prog_mask_q;
  logic        prog_we_q, prom_we_q, ovf_q, dl_q;
  entry_t      mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q;

  logic   push_req, fifo_empty, fifo_full, pop, bypass, push, drop, load;
  entry_t load_entry;

  // A byte arriving while idle with nothing queued skips the buffer, so a PROM write
  // pulses one cycle after its strobe and order is preserved.
  always_comb begin
    push_req   = bus.downloading & bus.ioctl_wr & in_keep;
    fifo_empty = (cnt_q == 2'd0);
    fifo_full  = (cnt_q == 2'd2);
    pop        = (state_q == StIdle) & ~fifo_empty;
    bypass     = (state_q == StIdle) & fifo_empty & push_req;
    push       = push_req & ~bypass & (~fifo_full | pop);
    drop       = push_req & fifo_full & ~pop;
    load       = pop | bypass;
    load_entry = pop ? mem_q[rd_ptr_q] : in_entry;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
    end else begin
      prom_we_q <= 1'b0;
      if (state_q == StWait) begin
        if (bus.sdram_ack) begin
          prog_we_q   <= 1'b0;
          prog_mask_q <= 2'b11;
          state_q     <= StIdle;
        end
      end else if (load) begin
        prog_addr_q <= load_entry.word;
        prog_data_q <= load_entry.data;
        if (load_entry.is_prom) begin
          prom_we_q   <= 1'b1;
          prog_mask_q <= 2'b11;
        end else begin
          prog_we_q   <= 1'b1;
          prog_mask_q <= load_entry.mask;
          state_q     <= StWait;
        end
      end
    end
  end

  // ovf is cleared by a new download starting; a drop in the same cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dl_q <= bus.downloading;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.downloading && !dl_q) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.prog_addr  = prog_addr_q;
  assign bus.prog_data  = prog_data_q;
  assign bus.prog_mask  = prog_mask_q;
  assign bus.prog_we    = prog_we_q;
  assign bus.prom_we    = prom_we_q;
  assign bus.ovf        = ovf_q;
  assign bus.dwnld_busy = bus.downloading | ~fifo_empty | (state_q == StWait);

endmodule
